// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch path.
package riscv_pkg;

  // Instruction-memory depth in words; fetch_instr and imem_loader both use this as NUM_INSTR.
  localparam int unsigned IMEM_WORDS = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  // States in which the loader consumes bytes from the stream.
  function automatic logic accepts_bytes(input loader_state_t st);
    return (st == ST_LEN_LO) || (st == ST_LEN_HI) || (st == ST_DATA) || (st == ST_CHECK);
  endfunction

  // States from which load_start restarts a load.
  function automatic logic can_start(input loader_state_t st);
    return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERROR);
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a byte stream into little-endian 32-bit words and keeps a running XOR checksum.
module imem_word_assembler (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word,
  output logic [7:0]  chk
);

  logic [1:0]  lane;
  logic [23:0] low_bytes;

  // Lane counter, lower three byte lanes and checksum; cleared at the start of each load.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lane      <= '0;
      low_bytes <= '0;
      chk       <= '0;
    end else if (clear) begin
      lane      <= '0;
      low_bytes <= '0;
      chk       <= '0;
    end else if (byte_en) begin
      lane <= lane + 2'd1;
      chk  <= chk ^ byte_data;
      case (lane)
        2'd0:    low_bytes[7:0]   <= byte_data;
        2'd1:    low_bytes[15:8]  <= byte_data;
        2'd2:    low_bytes[23:16] <= byte_data;
        default: low_bytes        <= low_bytes;
      endcase
    end
  end

  // The fourth byte completes the word directly from the input, so it need not be stored.
  always_comb begin
    word_valid = byte_en && (lane == 2'd3);
    word       = {byte_data, low_bytes};
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed program image into instruction memory and holds
// the core in reset until a verified image is present.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int unsigned NUM_INSTR = IMEM_WORDS,
  parameter int unsigned ADDR_W    = $clog2(NUM_INSTR)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              error
);

  loader_state_t state, state_next;

  logic [15:0]     len;
  logic [15:0]     len_in;
  logic [ADDR_W:0] word_cnt;
  logic            xfer;
  logic            start_load;
  logic            data_en;
  logic            last_word;
  logic            word_valid;
  logic [31:0]     word;
  logic [7:0]      chk;

  imem_word_assembler u_asm (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (start_load),
    .byte_en    (data_en),
    .byte_data  (byte_data),
    .word_valid (word_valid),
    .word       (word),
    .chk        (chk)
  );

  // Handshake decode and word-count bookkeeping derived from the current state.
  always_comb begin
    byte_ready = accepts_bytes(state);
    xfer       = byte_valid && byte_ready;
    start_load = load_start && can_start(state);
    data_en    = xfer && (state == ST_DATA);
    len_in     = {byte_data, len[7:0]};
    last_word  = (16'(word_cnt) + 16'd1) == len;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (load_start) state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (xfer) state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (xfer) begin
          if (len_in > 16'(NUM_INSTR)) state_next = ST_ERROR;
          else if (len_in == 16'd0)    state_next = ST_CHECK;
          else                         state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_valid && last_word) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (xfer) state_next = (byte_data == chk) ? ST_DONE : ST_ERROR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register, length/word counters and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      len        <= '0;
      word_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_next;
      imem_we    <= word_valid;
      done       <= (state_next == ST_DONE);
      error      <= (state_next == ST_ERROR);
      core_rst_n <= (state_next == ST_DONE);

      if (xfer && (state == ST_LEN_LO)) len[7:0]  <= byte_data;
      if (xfer && (state == ST_LEN_HI)) len[15:8] <= byte_data;

      if (start_load) begin
        word_cnt <= '0;
      end else if (word_valid) begin
        word_cnt <= word_cnt + 1'b1;
      end

      if (word_valid) begin
        imem_waddr <= word_cnt[ADDR_W-1:0];
        imem_wdata <= word;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: cycle-exact vector table plus multi-cycle sequences.
module tb_imem_loader;
  import riscv_pkg::*;

  localparam int unsigned NI = IMEM_WORDS;
  localparam int unsigned AW = $clog2(NI);

  logic          clk;
  logic          n_rst;
  logic          load_start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          done;
  logic          error;

  imem_loader #(.NUM_INSTR(NI), .ADDR_W(AW)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor against an expected word list.
  logic        mon_en = 1'b0;
  int          mon_idx = 0;
  logic [31:0] exp_words [0:NI-1];

  always @(negedge clk) begin
    if (mon_en && imem_we) begin
      if (mon_idx < int'(NI)) begin
        check($sformatf("mon_waddr%0d", mon_idx), 32'(imem_waddr), 32'(mon_idx));
        check($sformatf("mon_wdata%0d", mon_idx), imem_wdata, exp_words[mon_idx]);
      end else begin
        check("mon_extra_write", 32'(mon_idx), 32'(NI - 1));
      end
      mon_idx++;
    end
  end

  typedef struct {
    logic        ls;
    logic        bv;
    logic [7:0]  bd;
    logic        rdy;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        dn;
    logic        er;
    logic        cr;
  } vec_t;

  vec_t vecs [0:79];
  int   n_vec = 0;

  task automatic add(input logic ls, input logic bv, input logic [7:0] bd, input logic rdy,
                     input logic we, input logic [31:0] wa, input logic [31:0] wd,
                     input logic dn, input logic er, input logic cr);
    vecs[n_vec] = '{ls, bv, bd, rdy, we, wa, wd, dn, er, cr};
    n_vec++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int k = 0; k < 20; k++) begin
      if (byte_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    byte_data  = 8'hxx;
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
    if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Streams header, exp_words[0..n-1] and the checksum of those bytes.
  task automatic load_image(input int n, input int max_gap);
    logic [7:0] c;
    logic [31:0] w;
    c = 8'h00;
    send_byte(n[7:0], max_gap);
    send_byte(n[15:8], max_gap);
    for (int i = 0; i < n; i++) begin
      w = exp_words[i];
      for (int j = 0; j < 4; j++) begin
        c = c ^ w[8*j +: 8];
        send_byte(w[8*j +: 8], max_gap);
      end
    end
    send_byte(c, max_gap);
  endtask

  localparam logic [31:0] W0 = 32'h0000_0013;
  localparam logic [31:0] W1 = 32'h0010_0093;

  initial begin
    logic [31:0] w;
    n_rst      = 1'b0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    // Test 1: two-word image, with a stall in DATA, a stray load_start in DATA and a stall in CHECK.
    add(1,0,8'h00, 1,0,0,0,  0,0,0);
    add(0,1,8'h02, 1,0,0,0,  0,0,0);
    add(0,1,8'h00, 1,0,0,0,  0,0,0);
    add(0,1,8'h13, 1,0,0,0,  0,0,0);
    add(0,0,8'h55, 1,0,0,0,  0,0,0);
    add(0,1,8'h00, 1,0,0,0,  0,0,0);
    add(0,1,8'h00, 1,0,0,0,  0,0,0);
    add(0,1,8'h00, 1,1,0,W0, 0,0,0);
    add(1,1,8'h93, 1,0,0,W0, 0,0,0);
    add(0,1,8'h00, 1,0,0,W0, 0,0,0);
    add(0,1,8'h10, 1,0,0,W0, 0,0,0);
    add(0,1,8'h00, 1,1,1,W1, 0,0,0);
    add(1,0,8'h90, 1,0,1,W1, 0,0,0);
    add(0,1,8'h90, 0,0,1,W1, 1,0,1);
    add(0,1,8'h77, 0,0,1,W1, 1,0,1);
    // Test 2: same image, bad checksum, then restart from ERROR.
    add(1,0,8'h00, 1,0,1,W1, 0,0,0);
    add(0,1,8'h02, 1,0,1,W1, 0,0,0);
    add(0,1,8'h00, 1,0,1,W1, 0,0,0);
    add(0,1,8'h13, 1,0,1,W1, 0,0,0);
    add(0,1,8'h00, 1,0,1,W1, 0,0,0);
    add(0,1,8'h00, 1,0,1,W1, 0,0,0);
    add(0,1,8'h00, 1,1,0,W0, 0,0,0);
    add(0,1,8'h93, 1,0,0,W0, 0,0,0);
    add(0,1,8'h00, 1,0,0,W0, 0,0,0);
    add(0,1,8'h10, 1,0,0,W0, 0,0,0);
    add(0,1,8'h00, 1,1,1,W1, 0,0,0);
    add(0,1,8'h00, 0,0,1,W1, 0,1,0);
    add(1,0,8'h00, 1,0,1,W1, 0,0,0);
    // Test 3: length 65 exceeds depth -> ERROR, following bytes ignored.
    add(0,1,8'h41, 1,0,1,W1, 0,0,0);
    add(0,1,8'h00, 0,0,1,W1, 0,1,0);
    add(0,1,8'h13, 0,0,1,W1, 0,1,0);
    add(1,0,8'h00, 1,0,1,W1, 0,0,0);
    // Test 4: zero-length image, good then bad checksum.
    add(0,1,8'h00, 1,0,1,W1, 0,0,0);
    add(0,1,8'h00, 1,0,1,W1, 0,0,0);
    add(0,1,8'h00, 0,0,1,W1, 1,0,1);
    add(1,0,8'h00, 1,0,1,W1, 0,0,0);
    add(0,1,8'h00, 1,0,1,W1, 0,0,0);
    add(0,1,8'h00, 1,0,1,W1, 0,0,0);
    add(0,1,8'h05, 0,0,1,W1, 0,1,0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_we",    32'(imem_we),    32'd0);
    check("rst_waddr", 32'(imem_waddr), 32'd0);
    check("rst_wdata", imem_wdata,      32'd0);
    check("rst_crst",  32'(core_rst_n), 32'd0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_err",   32'(error),      32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready", 32'(byte_ready), 32'd0);

    for (int i = 0; i < n_vec; i++) begin
      @(negedge clk);
      load_start = vecs[i].ls;
      byte_valid = vecs[i].bv;
      byte_data  = vecs[i].bd;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ready", i), 32'(byte_ready), 32'(vecs[i].rdy));
      check($sformatf("v%0d_we", i),    32'(imem_we),    32'(vecs[i].we));
      check($sformatf("v%0d_waddr", i), 32'(imem_waddr), vecs[i].wa);
      check($sformatf("v%0d_wdata", i), imem_wdata,      vecs[i].wd);
      check($sformatf("v%0d_done", i),  32'(done),       32'(vecs[i].dn));
      check($sformatf("v%0d_err", i),   32'(error),      32'(vecs[i].er));
      check($sformatf("v%0d_crst", i),  32'(core_rst_n), 32'(vecs[i].cr));
    end
    @(negedge clk);
    load_start = 1'b0;
    byte_valid = 1'b0;

    // Test 5: full-depth image with random gaps between bytes.
    for (int i = 0; i < int'(NI); i++) begin
      w = 32'(i);
      exp_words[i] = {w[7:0] ^ 8'hA5, 8'hC3 ^ w[7:0], w[7:0], 8'h5A + w[7:0]};
    end
    pulse_start();
    mon_idx = 0;
    mon_en  = 1'b1;
    load_image(int'(NI), 3);
    repeat (2) @(negedge clk);
    check("full_nwrites",  32'(mon_idx),    32'(NI));
    check("full_lastaddr", 32'(imem_waddr), 32'(NI - 1));
    check("full_done",     32'(done),       32'd1);
    check("full_crst",     32'(core_rst_n), 32'd1);
    check("full_err",      32'(error),      32'd0);

    // Test 6: reset in the middle of DATA, then a fresh one-word load.
    pulse_start();
    mon_idx      = 0;
    exp_words[0] = 32'hDEAD_BEEF;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
    send_byte(8'h11, 0);
    @(negedge clk);
    check("abort_prewrite", 32'(mon_idx), 32'd1);
    n_rst = 1'b0;
    #1;
    check("abort_ready", 32'(byte_ready), 32'd0);
    check("abort_we",    32'(imem_we),    32'd0);
    check("abort_waddr", 32'(imem_waddr), 32'd0);
    check("abort_wdata", imem_wdata,      32'd0);
    check("abort_crst",  32'(core_rst_n), 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    mon_idx      = 0;
    exp_words[0] = 32'h1234_5678;
    pulse_start();
    load_image(1, 1);
    repeat (2) @(negedge clk);
    check("reload_nwrites", 32'(mon_idx),    32'd1);
    check("reload_done",    32'(done),       32'd1);
    check("reload_crst",    32'(core_rst_n), 32'd1);
    check("reload_err",     32'(error),      32'd0);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
